// File: rtl/req_recv_core_psn_check.sv
// -----------------------------------------------------------------------------
// req_recv_core_psn_check
//
// Responder-side request receive stage. It sits directly downstream of the
// context-fetch thread and takes one beat that carries the fetched QP context
// (head) and the echoed packet meta (data). The stage checks the QP state and
// the PSN, then routes the packet one of three ways:
//   - in order         : forward the meta to the execution thread and write
//                        back the advanced expected PSN (ePSN);
//   - out of order/dup : emit an ACK/NAK response meta;
//   - bad QP state or
//     malformed beat   : drop.
//
// Optional feature macro: REQ_RECV_PSN_DROP_CNT_EN
//   When it is defined, a saturating 32-bit drop_cnt output counts every entry
//   to DROP. When it is undefined, the port and the counter are absent.
//
// Ports
//   clk, rst_n                   clock, asynchronous active-low reset
//   fetch_cxt_egress_valid/ready context+meta beat handshake (ready comes from state)
//   fetch_cxt_egress_head        context: [23:0] ePSN, [26:24] QP state, [55:32] local QPN
//   fetch_cxt_egress_data        meta: [23:0] PSN, [31:24] opcode, [55:32] dest QPN
//   fetch_cxt_egress_start/last  beat framing; a valid packet is a single start&&last beat
//   exec_meta_valid/data/ready   in-order packet meta to the execution thread
//   cxt_update_valid/data/ready  ePSN writeback {local QPN, new ePSN}
//   resp_meta_valid/data/ready   ACK/NAK request {8'h0, syndrome, dest QPN, PSN}
//   drop_cnt                     (macro only) saturating drop counter
// -----------------------------------------------------------------------------
module req_recv_core_psn_check #(
    parameter int INGRESS_CXT_HEAD_WIDTH = 128,
    parameter int INGRESS_CXT_DATA_WIDTH = 256
) (
    input  logic                              clk,
    input  logic                              rst_n,

    input  logic                              fetch_cxt_egress_valid,
    input  logic [INGRESS_CXT_HEAD_WIDTH-1:0] fetch_cxt_egress_head,
    input  logic [INGRESS_CXT_DATA_WIDTH-1:0] fetch_cxt_egress_data,
    input  logic                              fetch_cxt_egress_start,
    input  logic                              fetch_cxt_egress_last,
    output logic                              fetch_cxt_egress_ready,

    output logic                              exec_meta_valid,
    output logic [INGRESS_CXT_DATA_WIDTH-1:0] exec_meta_data,
    input  logic                              exec_meta_ready,

    output logic                              cxt_update_valid,
    output logic [47:0]                       cxt_update_data,
    input  logic                              cxt_update_ready,

    output logic                              resp_meta_valid,
    output logic [63:0]                       resp_meta_data,
    input  logic                              resp_meta_ready
`ifdef REQ_RECV_PSN_DROP_CNT_EN
    ,
    output logic [31:0]                       drop_cnt
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DISCARD,
        S_JUDGE,
        S_FWD,
        S_RESP,
        S_DROP
    } state_t;

    localparam logic [2:0] QP_RTR       = 3'd3;
    localparam logic [2:0] QP_RTS       = 3'd4;
    localparam logic [7:0] SYNDROME_NAK = 8'h60;  // PSN sequence error NAK
    localparam logic [7:0] SYNDROME_ACK = 8'h00;

    state_t                            state;

    // Only the context fields the judgement needs are latched. The packet meta
    // is kept whole because it goes downstream unmodified.
    logic [23:0]                       cxt_epsn;
    logic [2:0]                        cxt_qp_state;
    logic [23:0]                       cxt_local_qpn;
    logic [INGRESS_CXT_DATA_WIDTH-1:0] meta_q;

    logic                              exec_done;
    logic                              upd_done;

    logic [23:0]                       pkt_psn;
    logic [23:0]                       pkt_dest_qpn;
    logic [23:0]                       psn_diff;
    logic                              qp_ok;
    logic                              exec_hs;
    logic                              upd_hs;
    logic                              resp_hs;
    logic                              head_unused;

    // The reserved context bits are never looked at.
    assign head_unused = ^{fetch_cxt_egress_head[INGRESS_CXT_HEAD_WIDTH-1:56],
                           fetch_cxt_egress_head[31:27]};

    assign pkt_psn      = meta_q[23:0];
    assign pkt_dest_qpn = meta_q[55:32];
    // Modulo-2^24 distance. The top bit splits "ahead of ePSN" (NAK) from
    // "behind ePSN" (duplicate).
    assign psn_diff     = pkt_psn - cxt_epsn;
    assign qp_ok        = (cxt_qp_state == QP_RTR) || (cxt_qp_state == QP_RTS);

    assign exec_hs = exec_meta_valid  && exec_meta_ready;
    assign upd_hs  = cxt_update_valid && cxt_update_ready;
    assign resp_hs = resp_meta_valid  && resp_meta_ready;

    // Ready is decoded from the state register. No beat is taken while a
    // packet is being judged or emitted.
    assign fetch_cxt_egress_ready = (state == S_IDLE) || (state == S_DISCARD);

    // NOTE: all state below is sequential and uses non-blocking assignments,
    // so every branch sees the pre-edge values and the order of branches
    // within the block does not matter except for deliberate last-write wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= S_IDLE;
            cxt_epsn         <= '0;
            cxt_qp_state     <= '0;
            cxt_local_qpn    <= '0;
            meta_q           <= '0;
            exec_done        <= 1'b0;
            upd_done         <= 1'b0;
            exec_meta_valid  <= 1'b0;
            exec_meta_data   <= '0;
            cxt_update_valid <= 1'b0;
            cxt_update_data  <= '0;
            resp_meta_valid  <= 1'b0;
            resp_meta_data   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (fetch_cxt_egress_valid && fetch_cxt_egress_start) begin
                        if (fetch_cxt_egress_last) begin
                            cxt_epsn      <= fetch_cxt_egress_head[23:0];
                            cxt_qp_state  <= fetch_cxt_egress_head[26:24];
                            cxt_local_qpn <= fetch_cxt_egress_head[55:32];
                            meta_q        <= fetch_cxt_egress_data;
                            state         <= S_JUDGE;
                        end else begin
                            state <= S_DISCARD;
                        end
                    end
                    // A stray non-start beat is consumed and ignored.
                end

                S_DISCARD: begin
                    if (fetch_cxt_egress_valid && fetch_cxt_egress_last) begin
                        state <= S_DROP;
                    end
                end

                S_JUDGE: begin
                    if (!qp_ok) begin
                        state <= S_DROP;
                    end else if (psn_diff == 24'd0) begin
                        exec_meta_valid  <= 1'b1;
                        exec_meta_data   <= meta_q;
                        cxt_update_valid <= 1'b1;
                        cxt_update_data  <= {cxt_local_qpn, cxt_epsn + 24'd1};
                        exec_done        <= 1'b0;
                        upd_done         <= 1'b0;
                        state            <= S_FWD;
                    end else if (!psn_diff[23]) begin
                        // Packet is ahead of ePSN: NAK that reports the expected PSN.
                        resp_meta_valid <= 1'b1;
                        resp_meta_data  <= {8'h00, SYNDROME_NAK, pkt_dest_qpn, cxt_epsn};
                        state           <= S_RESP;
                    end else begin
                        // Packet is behind ePSN: duplicate ACK that echoes its PSN.
                        resp_meta_valid <= 1'b1;
                        resp_meta_data  <= {8'h00, SYNDROME_ACK, pkt_dest_qpn, pkt_psn};
                        state           <= S_RESP;
                    end
                end

                S_FWD: begin
                    if (exec_hs) begin
                        exec_meta_valid <= 1'b0;
                        exec_done       <= 1'b1;
                    end
                    if (upd_hs) begin
                        cxt_update_valid <= 1'b0;
                        upd_done         <= 1'b1;
                    end
                    // The handshakes of this cycle count as done, so both
                    // channels completing together still leave in one step.
                    if ((exec_done || exec_hs) && (upd_done || upd_hs)) begin
                        exec_done <= 1'b0;
                        upd_done  <= 1'b0;
                        state     <= S_IDLE;
                    end
                end

                S_RESP: begin
                    if (resp_hs) begin
                        resp_meta_valid <= 1'b0;
                        state           <= S_IDLE;
                    end
                end

                S_DROP: begin
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef REQ_RECV_PSN_DROP_CNT_EN
    logic drop_enter;

    // Mirrors the two transitions into DROP above.
    assign drop_enter = ((state == S_DISCARD) && fetch_cxt_egress_valid && fetch_cxt_egress_last) ||
                        ((state == S_JUDGE) && !qp_ok);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt <= '0;
        end else if (drop_enter && (drop_cnt != 32'hFFFF_FFFF)) begin
            drop_cnt <= drop_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_req_recv_core_psn_check.sv
// -----------------------------------------------------------------------------
// tb_req_recv_core_psn_check
//
// Scoreboard bench for req_recv_core_psn_check. The stimulus process pushes
// the expected exec, update and response items into queues. A monitor process
// pops and compares an item whenever it sees a handshake on that channel.
// A handshake that arrives with no expected item is reported as unexpected.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_req_recv_core_psn_check;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         fetch_cxt_egress_valid = 1'b0;
    logic [127:0] fetch_cxt_egress_head = '0;
    logic [255:0] fetch_cxt_egress_data = '0;
    logic         fetch_cxt_egress_start = 1'b0;
    logic         fetch_cxt_egress_last = 1'b0;
    logic         fetch_cxt_egress_ready;
    logic         exec_meta_valid;
    logic [255:0] exec_meta_data;
    logic         exec_meta_ready = 1'b1;
    logic         cxt_update_valid;
    logic [47:0]  cxt_update_data;
    logic         cxt_update_ready = 1'b1;
    logic         resp_meta_valid;
    logic [63:0]  resp_meta_data;
    logic         resp_meta_ready = 1'b1;
`ifdef REQ_RECV_PSN_DROP_CNT_EN
    logic [31:0]  drop_cnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    logic [255:0] exp_exec[$];
    logic [47:0]  exp_upd[$];
    logic [63:0]  exp_resp[$];

    always #5 clk = ~clk;

    req_recv_core_psn_check #(
        .INGRESS_CXT_HEAD_WIDTH(128),
        .INGRESS_CXT_DATA_WIDTH(256)
    ) dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .fetch_cxt_egress_valid (fetch_cxt_egress_valid),
        .fetch_cxt_egress_head  (fetch_cxt_egress_head),
        .fetch_cxt_egress_data  (fetch_cxt_egress_data),
        .fetch_cxt_egress_start (fetch_cxt_egress_start),
        .fetch_cxt_egress_last  (fetch_cxt_egress_last),
        .fetch_cxt_egress_ready (fetch_cxt_egress_ready),
        .exec_meta_valid        (exec_meta_valid),
        .exec_meta_data         (exec_meta_data),
        .exec_meta_ready        (exec_meta_ready),
        .cxt_update_valid       (cxt_update_valid),
        .cxt_update_data        (cxt_update_data),
        .cxt_update_ready       (cxt_update_ready),
        .resp_meta_valid        (resp_meta_valid),
        .resp_meta_data         (resp_meta_data),
        .resp_meta_ready        (resp_meta_ready)
`ifdef REQ_RECV_PSN_DROP_CNT_EN
        ,
        .drop_cnt               (drop_cnt)
`endif
    );

    task automatic check(input string name, input logic [255:0] actual, input logic [255:0] expected);
        n_cmp++;
        if (actual !== expected) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic unexpected(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: handshake with no expected item", name);
    endtask

    function automatic logic [127:0] mk_head(input logic [23:0] epsn, input logic [2:0] st,
                                             input logic [23:0] qpn);
        logic [127:0] h;
        h = {64'hDEAD_BEEF_0000_1111, 8'h00, qpn, 5'b10101, st, epsn};
        return h;
    endfunction

    function automatic logic [255:0] mk_data(input logic [23:0] psn, input logic [7:0] op,
                                             input logic [23:0] dqpn, input logic [31:0] tag);
        logic [255:0] d;
        d = {{6{tag}}, 8'hA5, dqpn, op, psn};
        return d;
    endfunction

    // Monitor: every handshake pops one expected item from its channel.
    always @(negedge clk) begin
        if (rst_n) begin
            if (exec_meta_valid && exec_meta_ready) begin
                if (exp_exec.size() == 0) unexpected("exec_meta");
                else check("exec_meta_data", exec_meta_data, exp_exec.pop_front());
            end
            if (cxt_update_valid && cxt_update_ready) begin
                if (exp_upd.size() == 0) unexpected("cxt_update");
                else check("cxt_update_data", {208'h0, cxt_update_data}, {208'h0, exp_upd.pop_front()});
            end
            if (resp_meta_valid && resp_meta_ready) begin
                if (exp_resp.size() == 0) unexpected("resp_meta");
                else check("resp_meta_data", {192'h0, resp_meta_data}, {192'h0, exp_resp.pop_front()});
            end
        end
    end

    // Present one beat and hold it until the DUT takes it. Returns 1 ns after
    // the accepting edge.
    task automatic send_beat(input logic [127:0] h, input logic [255:0] d, input logic s, input logic l);
        int t;
        t = 0;
        fetch_cxt_egress_valid = 1'b1;
        fetch_cxt_egress_head  = h;
        fetch_cxt_egress_data  = d;
        fetch_cxt_egress_start = s;
        fetch_cxt_egress_last  = l;
        @(negedge clk);
        while (!fetch_cxt_egress_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) begin
            n_cmp++;
            n_bad++;
            $display("FAIL beat_accept: ready never rose within 100 cycles");
        end
        @(posedge clk);
        #1;
        fetch_cxt_egress_valid = 1'b0;
        fetch_cxt_egress_start = 1'b0;
        fetch_cxt_egress_last  = 1'b0;
    endtask

    // Wait (bounded) for IDLE with no output pending.
    task automatic wait_idle();
        int t;
        t = 0;
        @(negedge clk);
        while (!(fetch_cxt_egress_ready && !exec_meta_valid && !cxt_update_valid && !resp_meta_valid)
               && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) begin
            n_cmp++;
            n_bad++;
            $display("FAIL wait_idle: not idle within 100 cycles");
        end
        @(posedge clk);
        #1;
    endtask

    logic [127:0] h;
    logic [255:0] d;

    initial begin
        // Reset state.
        #12;
        check("reset_ready", {255'h0, fetch_cxt_egress_ready}, 256'h1);
        check("reset_exec_valid", {255'h0, exec_meta_valid}, 256'h0);
        check("reset_upd_valid", {255'h0, cxt_update_valid}, 256'h0);
        check("reset_resp_valid", {255'h0, resp_meta_valid}, 256'h0);
        check("reset_exec_data", exec_meta_data, 256'h0);
        check("reset_resp_data", {192'h0, resp_meta_data}, 256'h0);
`ifdef REQ_RECV_PSN_DROP_CNT_EN
        check("reset_drop_cnt", {224'h0, drop_cnt}, 256'h0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // In order, with latency checks: JUDGE after the accepting edge,
        // valids one edge later, IDLE one edge after that.
        h = mk_head(24'h000010, 3'd4, 24'h00ABCD);
        d = mk_data(24'h000010, 8'h0A, 24'h123456, 32'hC0FFEE01);
        exp_exec.push_back(d);
        exp_upd.push_back({24'h00ABCD, 24'h000011});
        send_beat(h, d, 1'b1, 1'b1);
        check("lat_judge_exec_valid", {255'h0, exec_meta_valid}, 256'h0);
        check("lat_judge_ready", {255'h0, fetch_cxt_egress_ready}, 256'h0);
        @(posedge clk);
        #1;
        check("lat_fwd_exec_valid", {255'h0, exec_meta_valid}, 256'h1);
        check("lat_fwd_upd_valid", {255'h0, cxt_update_valid}, 256'h1);
        @(posedge clk);
        #1;
        check("lat_back_idle", {255'h0, fetch_cxt_egress_ready}, 256'h1);
        wait_idle();

        // ePSN wraps from 0xFFFFFF to 0. QP state is RTR.
        h = mk_head(24'hFFFFFF, 3'd3, 24'h000777);
        d = mk_data(24'hFFFFFF, 8'h04, 24'h00BEEF, 32'h12345678);
        exp_exec.push_back(d);
        exp_upd.push_back({24'h000777, 24'h000000});
        send_beat(h, d, 1'b1, 1'b1);
        wait_idle();

        // Ahead of ePSN: NAK 0x60 with PSN field = ePSN.
        h = mk_head(24'h000100, 3'd4, 24'h000042);
        d = mk_data(24'h000105, 8'h00, 24'h0A0B0C, 32'h0);
        exp_resp.push_back({8'h00, 8'h60, 24'h0A0B0C, 24'h000100});
        send_beat(h, d, 1'b1, 1'b1);
        wait_idle();

        // Behind ePSN: duplicate ACK 0x00 with PSN field = packet PSN.
        h = mk_head(24'h000100, 3'd4, 24'h000042);
        d = mk_data(24'h0000FF, 8'h00, 24'h0D0E0F, 32'h0);
        exp_resp.push_back({8'h00, 8'h00, 24'h0D0E0F, 24'h0000FF});
        send_beat(h, d, 1'b1, 1'b1);
        wait_idle();

        // diff = 0x800000 is the first value that counts as a duplicate.
        h = mk_head(24'h000000, 3'd3, 24'h000042);
        d = mk_data(24'h800000, 8'h00, 24'h111111, 32'h0);
        exp_resp.push_back({8'h00, 8'h00, 24'h111111, 24'h800000});
        send_beat(h, d, 1'b1, 1'b1);
        wait_idle();

        // diff = 0x7FFFFF is the last value that counts as ahead (NAK).
        h = mk_head(24'h000001, 3'd3, 24'h000042);
        d = mk_data(24'h800000, 8'h00, 24'h222222, 32'h0);
        exp_resp.push_back({8'h00, 8'h60, 24'h222222, 24'h000001});
        send_beat(h, d, 1'b1, 1'b1);
        wait_idle();

        // QP in INIT: silently dropped, so no item is expected.
        h = mk_head(24'h000010, 3'd1, 24'h000042);
        d = mk_data(24'h000010, 8'h00, 24'h333333, 32'h0);
        send_beat(h, d, 1'b1, 1'b1);
        wait_idle();
`ifdef REQ_RECV_PSN_DROP_CNT_EN
        check("drop_cnt_bad_state", {224'h0, drop_cnt}, 256'h1);
`endif

        // A stray non-start beat in IDLE is ignored. Then a multi-beat packet
        // is consumed in full and dropped once.
        send_beat(h, d, 1'b0, 1'b0);
        check("stray_beat_ready", {255'h0, fetch_cxt_egress_ready}, 256'h1);
        send_beat(h, d, 1'b1, 1'b0);
        send_beat(h, d, 1'b0, 1'b0);
        send_beat(h, d, 1'b0, 1'b1);
        check("discard_end_ready", {255'h0, fetch_cxt_egress_ready}, 256'h0);
        wait_idle();
`ifdef REQ_RECV_PSN_DROP_CNT_EN
        check("drop_cnt_discard", {224'h0, drop_cnt}, 256'h2);
`endif

        // Exec backpressure for 5 cycles while the update completes at once.
        exec_meta_ready = 1'b0;
        h = mk_head(24'h0ABCDE, 3'd4, 24'h00FACE);
        d = mk_data(24'h0ABCDE, 8'h01, 24'h444444, 32'h55AA55AA);
        exp_exec.push_back(d);
        exp_upd.push_back({24'h00FACE, 24'h0ABCDF});
        send_beat(h, d, 1'b1, 1'b1);
        @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_exec_valid", {255'h0, exec_meta_valid}, 256'h1);
            check("stall_exec_data", exec_meta_data, d);
            @(posedge clk);
            #1;
        end
        check("stall_upd_released", {255'h0, cxt_update_valid}, 256'h0);
        exec_meta_ready = 1'b1;
        @(posedge clk);
        #1;
        check("stall_release_idle", {255'h0, fetch_cxt_egress_ready}, 256'h1);
        check("stall_release_valid", {255'h0, exec_meta_valid}, 256'h0);

        // Reset while both channels are held. The pending outputs are abandoned.
        exec_meta_ready  = 1'b0;
        cxt_update_ready = 1'b0;
        h = mk_head(24'h000020, 3'd4, 24'h000099);
        d = mk_data(24'h000020, 8'h02, 24'h555555, 32'h0);
        send_beat(h, d, 1'b1, 1'b1);
        @(posedge clk);
        #1;
        check("hold_exec_valid", {255'h0, exec_meta_valid}, 256'h1);
        check("hold_upd_valid", {255'h0, cxt_update_valid}, 256'h1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("midrst_exec_valid", {255'h0, exec_meta_valid}, 256'h0);
        check("midrst_upd_valid", {255'h0, cxt_update_valid}, 256'h0);
        check("midrst_resp_valid", {255'h0, resp_meta_valid}, 256'h0);
        check("midrst_ready", {255'h0, fetch_cxt_egress_ready}, 256'h1);
`ifdef REQ_RECV_PSN_DROP_CNT_EN
        check("midrst_drop_cnt", {224'h0, drop_cnt}, 256'h0);
`endif
        @(negedge clk);
        rst_n            = 1'b1;
        exec_meta_ready  = 1'b1;
        cxt_update_ready = 1'b1;
        @(posedge clk);
        #1;

        // Recovery after reset, with nothing from before the reset replayed.
        h = mk_head(24'h000020, 3'd4, 24'h000099);
        d = mk_data(24'h000020, 8'h03, 24'h666666, 32'h77777777);
        exp_exec.push_back(d);
        exp_upd.push_back({24'h000099, 24'h000021});
        send_beat(h, d, 1'b1, 1'b1);
        wait_idle();
        repeat (3) @(posedge clk);

        check("exec_queue_drained", 256'(exp_exec.size()), 256'h0);
        check("upd_queue_drained", 256'(exp_upd.size()), 256'h0);
        check("resp_queue_drained", 256'(exp_resp.size()), 256'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/req_recv_core_psn_check.md
# req_recv_core_psn_check

Responder-side request receive stage directly downstream of the context-fetch thread. Consumes the OoO-station egress beat, which carries the fetched QP context plus the echoed packet metadata. Validates QP state and PSN, then routes the packet one of three ways:
- in-order: forward to the execution thread and write back the advanced expected PSN;
- out-of-order or duplicate: emit an ACK/NAK response meta;
- bad QP state or malformed beat: drop.

## Interface
Parameters:
- INGRESS_CXT_HEAD_WIDTH, 128, egress head width; bits [23:0] ePSN, [26:24] QP state, [55:32] local QPN, rest reserved
- INGRESS_CXT_DATA_WIDTH, 256, egress data width; echoed packet meta: [23:0] PSN, [31:24] opcode, [55:32] dest QPN

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- fetch_cxt_egress_valid  in  1  context+meta beat valid
- fetch_cxt_egress_head  in  INGRESS_CXT_HEAD_WIDTH  fetched context
- fetch_cxt_egress_data  in  INGRESS_CXT_DATA_WIDTH  packet meta
- fetch_cxt_egress_start  in  1  first beat
- fetch_cxt_egress_last  in  1  last beat
- fetch_cxt_egress_ready  out  1  beat accepted
- exec_meta_valid  out  1  in-order packet meta valid
- exec_meta_data  out  INGRESS_CXT_DATA_WIDTH  latched packet meta, unmodified
- exec_meta_ready  in  1  downstream accept
- cxt_update_valid  out  1  ePSN writeback valid
- cxt_update_data  out  48  {local QPN[23:0], new ePSN[23:0]}
- cxt_update_ready  in  1  writeback accept
- resp_meta_valid  out  1  ACK/NAK request valid
- resp_meta_data  out  64  [23:0] PSN, [47:24] dest QPN, [55:48] syndrome, [63:56] 0
- resp_meta_ready  in  1  response generator accept

## Operation
States:
- IDLE:
  - fetch_cxt_egress_ready=1.
  - Beat with start&&last: latch head and data, go to JUDGE.
  - Beat with start&&!last: go to DISCARD.
  - Beat with !start: ignored (consumed).
- DISCARD: ready=1; consume beats until last, then go to DROP.
- JUDGE: single cycle; compute diff = (PSN − ePSN) mod 2^24.
  - QP state not 3'd3 (RTR) and not 3'd4 (RTS): go to DROP.
  - diff==0: go to FWD.
  - 1 ≤ diff ≤ 0x7FFFFF: go to RESP; NAK, syndrome 8'h60, PSN field = ePSN.
  - diff ≥ 0x800000: go to RESP; duplicate ACK, syndrome 8'h00, PSN field = packet PSN.
- FWD:
  - Assert exec_meta_valid and cxt_update_valid together.
  - New ePSN = (ePSN+1) mod 2^24, so 0xFFFFFF wraps to 0x000000.
  - Each valid drops independently on its own handshake; per-channel done flags are kept.
  - Go to IDLE when both channels are done, including when both complete in the same cycle.
- RESP: hold resp_meta_valid until resp_meta_ready, then go to IDLE.
- DROP: one cycle, then go to IDLE.

Rules:
- All outputs are registered.
- Data is stable while valid is high and not yet accepted.
- Valids never deassert without a handshake.
- No new beat is accepted outside IDLE and DISCARD.

## Timing
- Reset: state=IDLE; all valids, data, and counters 0; fetch_cxt_egress_ready=1 combinationally from state.
- Latency: beat accepted at cycle N; JUDGE at N+1; FWD/RESP valids are high at N+2 at the earliest.
- Minimum throughput: one packet per 3 cycles (IDLE→JUDGE→FWD with immediate readies).
- Reset mid-operation: pending outputs are abandoned and not replayed.
- Backpressure: readies low hold the FSM in FWD/RESP indefinitely; the upstream beat stays stalled.

## Configuration
- REQ_RECV_PSN_DROP_CNT_EN:
  - Defined: adds output drop_cnt (out, 32).
  - It counts each entry to DROP, saturating at 0xFFFFFFFF, and resets to 0.
  - Undefined: the port and counter are absent; all other behaviour is identical.

## Test plan
- ePSN=0x000010, PSN=0x000010, state=RTS, readies high → exec_meta_data equals input meta at N+2; cxt_update_data={QPN,0x000011}; back in IDLE at N+3.
- ePSN=0xFFFFFF, PSN=0xFFFFFF → cxt_update new ePSN=0x000000.
- ePSN=0x000100, PSN=0x000105 → resp_meta syndrome 8'h60, PSN field 0x000100; no exec or update.
- ePSN=0x000100, PSN=0x0000FF → resp syndrome 8'h00, PSN field 0x0000FF.
- State=3'd1 (INIT) → no outputs; drop_cnt increments by 1 when the macro is defined. Also drive start=1,last=0 then 2 beats ending in last → all beats consumed; one drop.
- FWD with exec_meta_ready low 5 cycles and cxt_update_ready high → update completes once; exec valid holds with stable data; FSM returns to IDLE in the cycle exec handshakes. Assert rst_n low mid-hold → all valids are 0 immediately.
